// File: rtl/puf_uart_tx.sv
// puf_uart_tx: captures a 128-bit PUF response on a fresh rising edge of
// puf_done and streams it as 16 UART frames, most-significant byte first,
// each frame LSB-first 8N1.
// Optional feature macro: PUF_UART_PARITY_EN -- when defined, an even parity
// bit follows data bit 7 (8E1 frames, 11 bit periods per frame).
module puf_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         puf_done,
  input  logic [127:0] puf_out,
  output logic         tx,
  output logic         busy,
  output logic         tx_done,
  output logic [4:0]   byte_cnt
);

  localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

`ifdef PUF_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_DONE
  } state_t;
`endif

  state_t         state;
  logic [127:0]   sr;
  logic [15:0]    baud;
  logic [2:0]     bit_idx;
  logic           done_q;
  logic           trig_q;   // rising edge seen in IDLE; capture follows one cycle later
  logic [7:0]     cur_byte;

  assign cur_byte = sr[127:120];

  // Frame sequencer: every output is registered and updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sr       <= '0;
      baud     <= '0;
      bit_idx  <= '0;
      done_q   <= 1'b0;
      trig_q   <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      byte_cnt <= '0;
    end else begin
      done_q <= puf_done;
      case (state)
        S_IDLE: begin
          tx     <= 1'b1;
          trig_q <= puf_done & ~done_q;
          if (trig_q) begin
            sr       <= puf_out;
            baud     <= BAUD_LOAD;
            byte_cnt <= '0;
            busy     <= 1'b1;
            tx_done  <= 1'b0;
            tx       <= 1'b0;
            trig_q   <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud == 16'd0) begin
            baud    <= BAUD_LOAD;
            bit_idx <= 3'd0;
            tx      <= cur_byte[0];
            state   <= S_DATA;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        S_DATA: begin
          if (baud == 16'd0) begin
            baud <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
`ifdef PUF_UART_PARITY_EN
              tx    <= ^cur_byte;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
`ifdef PUF_UART_PARITY_EN
        S_PARITY: begin
          if (baud == 16'd0) begin
            baud  <= BAUD_LOAD;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud == 16'd0) begin
            byte_cnt <= byte_cnt + 5'd1;
            sr       <= sr << 8;
            if (byte_cnt == 5'd15) begin
              tx      <= 1'b1;
              busy    <= 1'b0;
              tx_done <= 1'b1;
              state   <= S_DONE;
            end else begin
              // back-to-back frames: next start bit begins immediately
              baud  <= BAUD_LOAD;
              tx    <= 1'b0;
              state <= S_START;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        S_DONE: begin
          tx <= 1'b1;
          if (!puf_done) begin
            tx_done <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/puf_uart_tx.md
# puf_uart_tx

Downstream consumer of the 128-bit PUF response collector. It captures the 128-bit response when the collector raises its done flag, then streams it out as 16 UART frames for off-chip enrollment and characterisation. Bytes go most-significant first; each frame is LSB-first 8N1, or 8E1 when parity is compiled in. It re-arms only on a fresh rising edge of the done flag, so one response yields exactly one transmission.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- puf_done  in  1  response-valid level from the collector (held high while valid)
- puf_out  in  128  PUF response; sampled only at capture
- tx  out  1  UART serial line, idle high
- busy  out  1  high from capture until the last stop bit ends
- tx_done  out  1  high in DONE state
- byte_cnt  out  5  number of frames fully sent (0..16)

## Operation
- Rising-edge detect: `done_q` is puf_done delayed one cycle; reset value 0. Trigger = puf_done & ~done_q, evaluated only in IDLE.
- Reset values: tx=1, busy=0, tx_done=0, byte_cnt=0, state=IDLE, shift register=0, done_q=0.
- States:
  - IDLE: tx=1. On trigger, latch puf_out into a 128-bit shift register, load the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte bit[idx], LSB first; each bit lasts CLKS_PER_BIT cycles. After idx 7, go to PARITY if enabled, else STOP.
  - PARITY: tx = XOR of the 8 data bits (even parity); lasts CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then byte_cnt increments and the shift register shifts left by 8. If byte_cnt reaches 16, go to DONE; else go to START immediately, with no idle gap.
  - DONE: tx=1, busy=0, tx_done=1. Return to IDLE in the cycle after puf_done is sampled low. byte_cnt holds 16 until the next capture, which clears it to 0.
- Current byte = shift register [127:120], so puf_out[127:120] is sent first and puf_out[7:0] last.
- Baud counter: 16-bit, counts CLKS_PER_BIT-1 down to 0. A bit period ends on the cycle the counter is 0.
- The puf_out value is frozen at capture; later changes have no effect on the transmission in progress.
- puf_done falling mid-transmission is ignored; the transmission completes.
- rst mid-transmission: all outputs return to reset values on the next edge and the partial frame is abandoned. If puf_done is still high after reset, done_q=0 re-triggers a full transmission.

## Timing
- Capture: trigger sampled at edge N; capture and START entry at edge N+1, with tx low from N+1.
- Frame length F = 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- busy is high for exactly 16·F cycles, starting at edge N+1.
- tx_done rises at edge N+1+16·F. If puf_done is already low, tx_done is high for exactly 1 cycle.
- Minimum time from DONE exit to the next capture: 2 cycles (IDLE entry, then a new trigger).

## Configuration
- PUF_UART_PARITY_EN defined: PARITY state present; even parity bit inserted after bit 7; F = 11·CLKS_PER_BIT.
- PUF_UART_PARITY_EN undefined: PARITY state and its logic are absent; 8N1 frames; F = 10·CLKS_PER_BIT.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- puf_out=128'h5468697349734E6F74576F726B696E67, puf_done 0→1 (no parity) -> first frame on tx: start 0, then bits 0,0,1,0,1,0,1,0, then stop 1, each bit 4 cycles. Decoded bytes are 54 68 … 67. busy is high for 640 cycles; tx_done=1 and byte_cnt=16 at the end.
- puf_out changed to all-ones at byte_cnt=3 -> every decoded byte still matches the captured value.
- puf_done held high after DONE -> no second transmission and tx stays 1. Drop puf_done for 1 cycle then raise it -> a second full 16-byte transmission starts 3 cycles after the drop.
- rst pulsed during the 5th frame's DATA state with puf_done high -> next cycle tx=1, busy=0, byte_cnt=0. A new full transmission starts 2 cycles after rst deasserts.
- PUF_UART_PARITY_EN defined, byte 0x54 -> parity bit 1 (three ones). Byte 0x6F -> parity bit 0. busy lasts 704 cycles.
- puf_done falls during frame 2 -> all 16 frames are sent; tx_done is high for 1 cycle, then state returns to IDLE.
